// File: rtl/asic_mem_responder.sv
// Fixed-latency 64-bit word memory responder with byte/half/word/double access.
// Define ASIC_MEM_RESPONDER_STALL_EN to insert one idle ready cycle after each accept.
module asic_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_valid_i,
    output logic        mem_req_ready_o,
    input  logic [4:0]  mem_req_cmd_i,
    input  logic [2:0]  mem_req_typ_i,
    input  logic [39:0] mem_req_addr_i,
    input  logic [63:0] mem_req_data_i,
    output logic        mem_resp_valid_o,
    output logic [4:0]  mem_resp_cmd_o,
    output logic [2:0]  mem_resp_typ_o,
    output logic [39:0] mem_resp_addr_o,
    output logic [63:0] mem_resp_data_o
);
    localparam int AW = $clog2(NUM_WORDS);

    logic [63:0]    mem [NUM_WORDS];
    logic           accept;
    logic           typ_ok;
    logic           is_load;
    logic           is_store;
    logic [1:0]     size;
    logic [2:0]     off;
    logic [7:0]     bmask;
    logic [7:0]     be;
    logic [63:0]    wdata;
    logic [63:0]    shifted;
    logic [63:0]    ld_data;
    logic [63:0]    resp_data;
    logic [AW-1:0]  widx;

    logic [LATENCY-1:0] pv;
    logic [4:0]         pcmd  [LATENCY];
    logic [2:0]         ptyp  [LATENCY];
    logic [39:0]        paddr [LATENCY];
    logic [63:0]        pdata [LATENCY];

`ifdef ASIC_MEM_RESPONDER_STALL_EN
    logic stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= accept;
        end
    end

    assign mem_req_ready_o = ~reset & ~stall_q;
`else
    assign mem_req_ready_o = ~reset;
`endif

    assign accept   = mem_req_valid_i & mem_req_ready_o;
    assign typ_ok   = (mem_req_typ_i != 3'd7);
    assign is_load  = typ_ok & (mem_req_cmd_i == 5'd0);
    assign is_store = typ_ok & (mem_req_cmd_i == 5'd1);
    assign size     = mem_req_typ_i[1:0];
    assign widx     = mem_req_addr_i[3 +: AW];

    // Offset is aligned down to the access size before it steers bytes.
    always_comb begin
        off   = 3'd0;
        bmask = 8'hFF;
        unique case (size)
            2'd0: begin off = mem_req_addr_i[2:0];         bmask = 8'h01; end
            2'd1: begin off = {mem_req_addr_i[2:1], 1'b0}; bmask = 8'h03; end
            2'd2: begin off = {mem_req_addr_i[2], 2'b00};  bmask = 8'h0F; end
            2'd3: begin off = 3'd0;                        bmask = 8'hFF; end
        endcase
    end

    assign be      = bmask << off;
    assign wdata   = mem_req_data_i << {off, 3'b000};
    assign shifted = mem[widx] >> {off, 3'b000};

    always_comb begin
        ld_data = shifted;
        unique case (size)
            2'd0: ld_data = mem_req_typ_i[2] ? {56'd0, shifted[7:0]}
                                             : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: ld_data = mem_req_typ_i[2] ? {48'd0, shifted[15:0]}
                                             : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: ld_data = mem_req_typ_i[2] ? {32'd0, shifted[31:0]}
                                             : {{32{shifted[31]}}, shifted[31:0]};
            2'd3: ld_data = shifted;
        endcase
    end

    assign resp_data = is_load ? ld_data : 64'd0;

    // Storage is deliberately not reset; only the pipeline valids are.
    always_ff @(posedge clk) begin
        if (accept && is_store) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pcmd[0]  <= mem_req_cmd_i;
        ptyp[0]  <= mem_req_typ_i;
        paddr[0] <= mem_req_addr_i;
        pdata[0] <= resp_data;
        for (int i = 1; i < LATENCY; i++) begin
            pcmd[i]  <= pcmd[i-1];
            ptyp[i]  <= ptyp[i-1];
            paddr[i] <= paddr[i-1];
            pdata[i] <= pdata[i-1];
        end
    end

    assign mem_resp_valid_o = pv[LATENCY-1] & ~reset;
    assign mem_resp_cmd_o   = mem_resp_valid_o ? pcmd[LATENCY-1]  : 5'd0;
    assign mem_resp_typ_o   = mem_resp_valid_o ? ptyp[LATENCY-1]  : 3'd0;
    assign mem_resp_addr_o  = mem_resp_valid_o ? paddr[LATENCY-1] : 40'd0;
    assign mem_resp_data_o  = mem_resp_valid_o ? pdata[LATENCY-1] : 64'd0;

endmodule

// File: tb/tb_asic_mem_responder.sv
// Bench for asic_mem_responder: byte-array reference model plus directed and
// random request streams; honours ASIC_MEM_RESPONDER_STALL_EN when defined.
module tb_asic_mem_responder;
    localparam int NW  = 256;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_cmd;
    logic [2:0]  req_typ;
    logic [39:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid;
    logic [4:0]  resp_cmd;
    logic [2:0]  resp_typ;
    logic [39:0] resp_addr;
    logic [63:0] resp_data;

    asic_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_req_valid_i  (req_valid),
        .mem_req_ready_o  (req_ready),
        .mem_req_cmd_i    (req_cmd),
        .mem_req_typ_i    (req_typ),
        .mem_req_addr_i   (req_addr),
        .mem_req_data_i   (req_data),
        .mem_resp_valid_o (resp_valid),
        .mem_resp_cmd_o   (resp_cmd),
        .mem_resp_typ_o   (resp_typ),
        .mem_resp_addr_o  (resp_addr),
        .mem_resp_data_o  (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [39:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] got [$];
    logic [7:0]  mb [NW*8];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    bit          stalled = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int nbytes(input logic [2:0] t);
        return 1 << (t % 4);
    endfunction

    function automatic int base_of(input logic [39:0] a, input logic [2:0] t);
        int n;
        int o;
        n = nbytes(t);
        o = int'(a % 8);
        o = o - (o % n);
        return int'((a / 8) % NW) * 8 + o;
    endfunction

    function automatic logic [63:0] model_load(input logic [39:0] a, input logic [2:0] t);
        logic [63:0] v;
        int n;
        int b;
        n = nbytes(t);
        b = base_of(a, t);
        v = 64'd0;
        for (int k = 0; k < n; k++) v = v | (64'(mb[b+k]) << (8*k));
        if (t < 3 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic step(input logic r, input logic v, input logic [4:0] c,
                        input logic [2:0] t, input logic [39:0] a, input logic [63:0] d);
        exp_t e;
        logic er;
        logic ev;
        int   b;
        @(negedge clk);
        reset = r; req_valid = v; req_cmd = c; req_typ = t;
        req_addr = a; req_data = d;
        #1;
        if (r) begin
            exp_q.delete();
            stalled = 0;
        end
        er = !r && !stalled;
        chk("ready", 64'(req_ready), 64'(er));
        e = '{0, 5'd0, 3'd0, 40'd0, 64'd0};
        ev = 1'b0;
        if (!r && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            ev = 1'b1;
        end
        chk("resp_valid", 64'(resp_valid), 64'(ev));
        chk("resp_cmd", 64'(resp_cmd), 64'(e.cmd));
        chk("resp_typ", 64'(resp_typ), 64'(e.typ));
        chk("resp_addr", 64'(resp_addr), 64'(e.addr));
        chk("resp_data", resp_data, e.data);
        if (resp_valid) got.push_back(resp_data);
        if (v && er) begin
            n_acc++;
            e = '{cyc + LAT, c, t, a, 64'd0};
            if (c == 0 && t != 7) e.data = model_load(a, t);
            if (c == 1 && t != 7) begin
                b = base_of(a, t);
                for (int k = 0; k < nbytes(t); k++) mb[b+k] = d[8*k +: 8];
            end
            exp_q.push_back(e);
        end
`ifdef ASIC_MEM_RESPONDER_STALL_EN
        stalled = v && er;
`else
        stalled = 0;
`endif
        @(posedge clk);
        cyc++;
    endtask

    task automatic req(input logic [4:0] c, input logic [2:0] t,
                       input logic [39:0] a, input logic [63:0] d);
        step(1'b0, 1'b1, c, t, a, d);
`ifdef ASIC_MEM_RESPONDER_STALL_EN
        step(1'b0, 1'b0, 5'd0, 3'd0, 40'd0, 64'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 3'd0, 40'd0, 64'd0);
    endtask

    initial begin
        int exp_acc;
        logic [4:0] c;
        int r;
        reset = 1'b1; req_valid = 1'b0; req_cmd = 5'd0; req_typ = 3'd0;
        req_addr = 40'd0; req_data = 64'd0;

        step(1'b1, 1'b0, 5'd0, 3'd0, 40'd0, 64'd0);
        step(1'b1, 1'b1, 5'd0, 3'd3, 40'd0, 64'd0);
        idle(1);

        // Fill every word so later loads never see uninitialised storage.
        for (int w = 0; w < NW; w++) req(5'd1, 3'd3, 40'(w * 8), {$urandom, $urandom});
        idle(LAT + 1);

        got.delete();
        req(5'd1, 3'd3, 40'h10, 64'h0123_4567_89AB_CDEF);
        req(5'd0, 3'd3, 40'h10, 64'd0);
        idle(LAT + 1);
        chk("ld_d", got[$], 64'h0123_4567_89AB_CDEF);

        got.delete();
        req(5'd1, 3'd0, 40'h13, 64'h80);
        req(5'd0, 3'd0, 40'h13, 64'd0);
        req(5'd0, 3'd4, 40'h13, 64'd0);
        req(5'd0, 3'd3, 40'h10, 64'd0);
        idle(LAT + 1);
        chk("ld_b", got[1], 64'hFFFF_FFFF_FFFF_FF80);
        chk("ld_bu", got[2], 64'h0000_0000_0000_0080);
        chk("ld_b_nbr", got[3], 64'h0123_4567_80AB_CDEF);

        got.delete();
        step(1'b0, 1'b1, 5'd1, 3'd2, 40'h24, 64'hDEAD_BEEF);
        step(1'b0, 1'b1, 5'd0, 3'd6, 40'h24, 64'd0);
        idle(LAT + 2);
        chk("ld_wu", got[$], 64'h0000_0000_DEAD_BEEF);

        got.delete();
        req(5'd1, 3'd3, 40'h800, 64'hA5A5_0000_1234_5678);
        req(5'd0, 3'd3, 40'h000, 64'd0);
        req(5'd2, 3'd3, 40'h000, 64'hFFFF);
        req(5'd1, 3'd7, 40'h000, 64'hFFFF);
        req(5'd0, 3'd3, 40'h000, 64'd0);
        idle(LAT + 1);
        chk("wrap", got[1], 64'hA5A5_0000_1234_5678);
        chk("unsup", got[4], 64'hA5A5_0000_1234_5678);

        got.delete();
        req(5'd0, 3'd3, 40'h10, 64'd0);
        req(5'd0, 3'd3, 40'h800, 64'd0);
        got.delete();
        step(1'b1, 1'b0, 5'd0, 3'd0, 40'd0, 64'd0);
        idle(LAT + 2);
        chk("rst_drop", 64'(got.size()), 64'd0);
        req(5'd0, 3'd3, 40'h10, 64'd0);
        idle(LAT + 1);
        chk("rst_keep", got[$], 64'h0123_4567_80AB_CDEF);

        n_acc = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd0, 3'd3, 40'h10, 64'd0);
`ifdef ASIC_MEM_RESPONDER_STALL_EN
        exp_acc = 4;
`else
        exp_acc = 8;
`endif
        chk("accepts8", 64'(n_acc), 64'(exp_acc));
        idle(LAT + 1);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) c = 5'd0;
            else if (r < 8) c = 5'd1;
            else c = 5'($urandom_range(2, 31));
            step(1'b0, 1'($urandom_range(0, 3) != 0), c, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom} & 40'h1FFF, {$urandom, $urandom});
        end
        idle(LAT + 2);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/asic_mem_responder.md
ASIC_MEM_RESPONDER -- requirements
Module: asic_mem_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256, meaning number of 64-bit storage words (power of 2, 2..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning request-accept to response-valid delay in cycles (1..4).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port mem_req_valid_i, input, 1, meaning requester has a request.
REQ-006 SHALL have port mem_req_ready_o, output, 1, meaning responder accepts a request this cycle.
REQ-007 SHALL have port mem_req_cmd_i, input, 5, meaning 0 = load, 1 = store, others unsupported.
REQ-008 SHALL have port mem_req_typ_i, input, 3, meaning size/sign: 0 = B, 1 = H, 2 = W, 3 = D, 4 = BU, 5 = HU, 6 = WU, 7 unsupported.
REQ-009 SHALL have port mem_req_addr_i, input, 40, meaning byte address.
REQ-010 SHALL have port mem_req_data_i, input, 64, meaning store data, right-aligned.
REQ-011 SHALL have port mem_resp_valid_o, output, 1, meaning response present; no ready exists, so the requester must sink it that cycle.
REQ-012 SHALL have ports mem_resp_cmd_o (5), mem_resp_typ_o (3), mem_resp_addr_o (40), all outputs, meaning cmd, typ and addr echoed from the originating request.
REQ-013 SHALL have port mem_resp_data_o, output, 64, meaning load data, right-aligned and extended.

Function
REQ-014 SHALL accept a request on any rising edge where mem_req_valid_i and mem_req_ready_o are both 1.
REQ-015 SHALL assert mem_resp_valid_o exactly LATENCY cycles after acceptance, for one cycle, with no reordering.
REQ-016 SHALL sustain one accepted request per cycle with up to LATENCY requests in flight.
REQ-017 SHALL select the word as addr[3+log2(NUM_WORDS)-1:3]; higher address bits are ignored, so addresses wrap.
REQ-018 SHALL take the byte offset from addr[2:0], aligned down to the access size: H clears bit 0, W clears bits 1:0, D uses offset 0.
REQ-019 SHALL, on a store, write only the addressed bytes at the acceptance edge; all other bytes are unchanged.
REQ-020 SHALL, on a load, sample the array at the acceptance edge, so a load accepted the cycle after a store to the same bytes returns the new data.
REQ-021 SHALL sign-extend load data for B/H/W, zero-extend it for BU/HU/WU, and return D unmodified.
REQ-022 SHALL return mem_resp_data_o = 0 for stores, unsupported cmd and typ 7; unsupported requests still get a response and write nothing.
REQ-023 SHALL drive mem_resp_cmd_o, typ_o, addr_o and data_o to 0 whenever mem_resp_valid_o = 0.

Reset
REQ-024 SHALL, while reset = 1, drive mem_req_ready_o = 0 and mem_resp_valid_o = 0, and clear every in-flight pipeline valid bit.
REQ-025 SHALL drop in-flight requests when reset is asserted mid-operation; they produce no response afterwards.
REQ-026 SHALL NOT reset storage array contents.
REQ-027 SHALL drive mem_req_ready_o = 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, when macro ASIC_MEM_RESPONDER_STALL_EN is defined, deassert mem_req_ready_o for exactly one cycle after each accepted request, capping throughput at one request per two cycles; response latency is unchanged.
REQ-029 SHALL, when ASIC_MEM_RESPONDER_STALL_EN is undefined, hold mem_req_ready_o = 1 in every non-reset cycle.

Verification
REQ-030 SHALL cover: store D 0x0123456789ABCDEF to 0x10, then load D from 0x10 -> resp data 0x0123456789ABCDEF, arriving LATENCY cycles after the load is accepted.
REQ-031 SHALL cover: store B 0x80 to 0x13, then load B and load BU from 0x13 -> 0xFFFFFFFFFFFFFF80 and 0x0000000000000080; bytes 0x10-0x12 and 0x14-0x17 unchanged.
REQ-032 SHALL cover: back-to-back store W 0xDEADBEEF to 0x24 then load WU from 0x24 on the next cycle -> 0x00000000DEADBEEF, with responses in issue order.
REQ-033 SHALL cover: with NUM_WORDS = 256, store D to 0x800 then load D from 0x000 -> same data (wrap).
REQ-034 SHALL cover: reset asserted while 2 loads are in flight -> no mem_resp_valid_o for them; ready returns 1 after reset; memory contents are retained.
REQ-035 SHALL cover: with ASIC_MEM_RESPONDER_STALL_EN defined and valid held high for 8 cycles -> ready toggles 1/0 and exactly 4 requests are accepted.
